// File: rtl/redirect_ctrl.sv
// redirect_ctrl: sequences the front-end response to an EX branch mispredict or an exception flush.
// Latency: EX accept at cycle N with the delay slot already in ID gives redirect_valid/flush_if at N+1; all outputs registered.
// Backpressure: redirect_valid and redirect_pc hold until redirect_ready; EX redirects arriving while busy are dropped and flagged.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pipe_stall                     backend stall; EX redirect ignored while high
//   ex_redirect_valid/_pc          mispredict request and correct target from EX
//   ds_in_id, ds_arrive            delay slot position / arrival pulse in ID
//   exc_flush_valid, exc_pc        exception/eret flush request and its target
//   redirect_valid/_ready/_pc      valid/ready redirect request to fetch
//   flush_if, flush_id             one-cycle stage kill pulses
//   fetch_hold                     fetch must not issue (penalty window)
//   busy, err_overlap              FSM not idle / sticky overlap error
//   mispredict_cnt                 saturating count of accepted EX redirects
module redirect_ctrl #(
    parameter int PENALTY_CYCLES = 0,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_stall,
    input  logic             ex_redirect_valid,
    input  logic [31:0]      ex_redirect_pc,
    input  logic             ds_in_id,
    input  logic             ds_arrive,
    input  logic             exc_flush_valid,
    input  logic [31:0]      exc_pc,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if,
    output logic             flush_id,
    output logic             fetch_hold,
    output logic             busy,
    output logic             err_overlap,
    output logic [CNT_W-1:0] mispredict_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DS  = 2'd1,
        REDIRECT = 2'd2,
        PENALTY  = 2'd3
    } state_t;

    localparam logic [3:0] PEN_LOAD = 4'(PENALTY_CYCLES);

    state_t             state_q, state_d;
    logic [3:0]         pen_cnt_q, pen_cnt_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic               flush_if_q, flush_if_d;
    logic               flush_id_q, flush_id_d;
    logic               fetch_hold_q, fetch_hold_d;
    logic               busy_q, busy_d;
    logic               err_overlap_q, err_overlap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ex_take;

    // A stalled backend means EX outputs are meaningless: drop them entirely.
    assign ex_take = ex_redirect_valid && !pipe_stall;

    always_comb begin
        state_d       = state_q;
        pen_cnt_d     = pen_cnt_q;
        redirect_pc_d = redirect_pc_q;
        flush_if_d    = 1'b0;
        flush_id_d    = 1'b0;
        err_overlap_d = err_overlap_q;
        cnt_d         = cnt_q;

        if (exc_flush_valid) begin
            // Exceptions win in every state and restart the redirect from scratch.
            state_d       = REDIRECT;
            redirect_pc_d = exc_pc;
            flush_if_d    = 1'b1;
            flush_id_d    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ex_take) begin
                        redirect_pc_d = ex_redirect_pc;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (ds_in_id) begin
                            state_d    = REDIRECT;
                            flush_if_d = 1'b1;
                        end else begin
                            state_d = WAIT_DS;
                        end
                    end
                end
                WAIT_DS: begin
                    if (ds_arrive) begin
                        state_d    = REDIRECT;
                        flush_if_d = 1'b1;
                    end
                end
                REDIRECT: begin
                    // redirect_valid is always high in this state, so ready alone is the handshake.
                    if (redirect_ready) begin
                        if (PEN_LOAD != 4'd0) begin
                            state_d   = PENALTY;
                            pen_cnt_d = PEN_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                PENALTY: begin
                    pen_cnt_d = pen_cnt_q - 4'd1;
                    if (pen_cnt_q <= 4'd1) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (ex_take && (state_q != IDLE)) begin
                err_overlap_d = 1'b1;
            end
        end

        // Outputs are registered views of the next state.
        redirect_valid_d = (state_d == REDIRECT);
        fetch_hold_d     = (state_d == PENALTY);
        busy_d           = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            pen_cnt_q        <= 4'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            flush_if_q       <= 1'b0;
            flush_id_q       <= 1'b0;
            fetch_hold_q     <= 1'b0;
            busy_q           <= 1'b0;
            err_overlap_q    <= 1'b0;
            cnt_q            <= '0;
        end else begin
            state_q          <= state_d;
            pen_cnt_q        <= pen_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_if_q       <= flush_if_d;
            flush_id_q       <= flush_id_d;
            fetch_hold_q     <= fetch_hold_d;
            busy_q           <= busy_d;
            err_overlap_q    <= err_overlap_d;
            cnt_q            <= cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_if       = flush_if_q;
    assign flush_id       = flush_id_q;
    assign fetch_hold     = fetch_hold_q;
    assign busy           = busy_q;
    assign err_overlap    = err_overlap_q;
    assign mispredict_cnt = cnt_q;

endmodule

// File: doc/redirect_ctrl.md
Name: redirect_ctrl

Overview:
- Sequences the front-end response to a branch mispredict reported by the execute stage, or to a higher-priority exception flush.
- Latches the redirect target and waits until the MIPS delay slot is safely in ID.
- Issues stage flush pulses, then holds a valid/ready redirect request to fetch until fetch accepts it.
- Inserts an optional fetch-hold penalty and keeps a saturating mispredict counter.
- Sits between the execute-stage PC check and the fetch/IF-ID pipeline control.

Parameters:
- PENALTY_CYCLES, 0: cycles of fetch_hold after redirect acceptance, range 0..15.
- CNT_W, 16: width of the mispredict counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pipe_stall  in  1  backend stall; EX outputs are not valid while high.
- ex_redirect_valid  in  1  mispredict from EX (execute PC-check enable).
- ex_redirect_pc  in  32  correct target from EX.
- ds_in_id  in  1  delay slot of the EX branch currently occupies ID.
- ds_arrive  in  1  pulse: delay slot entered ID this cycle.
- exc_flush_valid  in  1  exception/eret flush request.
- exc_pc  in  32  exception vector / return PC.
- redirect_ready  in  1  fetch accepts redirect.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  32  redirect target.
- flush_if  out  1  one-cycle pulse: kill IF-stage instruction.
- flush_id  out  1  one-cycle pulse: kill ID-stage instruction (exceptions only).
- fetch_hold  out  1  fetch must not issue.
- busy  out  1  FSM not in IDLE.
- err_overlap  out  1  sticky: EX redirect arrived while busy.
- mispredict_cnt  out  CNT_W  accepted EX redirects, saturating.

Behaviour:
- All outputs are registered. On reset, every output is 0 and the state is IDLE; reset mid-operation abandons any pending redirect.
- States: IDLE, WAIT_DS, REDIRECT, PENALTY.
- EX redirect is accepted only in IDLE with ex_redirect_valid=1 and pipe_stall=0.
  - On accept, latch ex_redirect_pc into redirect_pc and increment mispredict_cnt, saturating at all-ones.
  - If ds_in_id=1: next state REDIRECT, with redirect_valid=1 and a flush_if pulse in the first REDIRECT cycle.
  - If ds_in_id=0: next state WAIT_DS.
- WAIT_DS:
  - Outputs fetch_hold=0 so the delay slot can be fetched.
  - On ds_arrive=1, next state REDIRECT with a flush_if pulse in its first cycle.
- REDIRECT:
  - redirect_valid=1 and redirect_pc stay stable until a cycle with redirect_ready=1. That cycle is the handshake.
  - After the handshake, redirect_valid=0 the next cycle and the state goes to PENALTY if PENALTY_CYCLES>0, else IDLE.
  - flush_if/flush_id are asserted only in the first REDIRECT cycle after entry.
- PENALTY:
  - fetch_hold=1 for exactly PENALTY_CYCLES cycles, using a 4-bit down-counter loaded on the handshake; then IDLE.
- Exception flush has the highest priority and is accepted in any state, including same-cycle with an EX redirect. It ignores pipe_stall.
  - Latch exc_pc, go to REDIRECT, and pulse flush_if and flush_id in the first REDIRECT cycle.
  - Does not increment mispredict_cnt. A simultaneous EX redirect is dropped and does not set err_overlap.
  - Arriving during REDIRECT, it replaces redirect_pc even mid-handshake-wait, restarts REDIRECT, and pulses flushes again.
- An EX redirect arriving while busy=1 (no exception that cycle) is dropped and sets err_overlap. err_overlap clears only on rst.
- ex_redirect_valid while pipe_stall=1 is ignored entirely: no count, no error.
- busy=1 in every non-IDLE state. A new EX redirect may be accepted in the cycle after returning to IDLE.
- Latency: EX accept at cycle N with ds_in_id=1 gives redirect_valid=1 and flush_if=1 at cycle N+1.

Test Plan:
- Basic redirect: ex_redirect_valid=1, pc=0x0040_0100, ds_in_id=1, redirect_ready=1 at N+1 -> redirect_valid and flush_if high only at N+1, redirect_pc=0x0040_0100, mispredict_cnt=1, IDLE at N+2.
- Delay slot wait: accept with ds_in_id=0, ds_arrive at N+3 -> no redirect_valid at N+1..N+3; redirect_valid and flush_if at N+4.
- Backpressure: redirect_ready low for 5 cycles -> redirect_valid and redirect_pc stay stable; flush_if pulses once; a second EX redirect during the wait sets err_overlap=1 and is not counted.
- Exception override: in REDIRECT to 0x100, exc_flush_valid with exc_pc=0xBFC0_0380 -> next cycle redirect_pc=0xBFC0_0380, flush_if=flush_id=1, counter unchanged.
- Penalty and stall: PENALTY_CYCLES=3 -> fetch_hold high exactly 3 cycles after handshake; ex_redirect_valid with pipe_stall=1 is ignored.
- Saturation and reset: CNT_W=2 with 5 accepted redirects -> mispredict_cnt=3. Assert rst mid-WAIT_DS -> all outputs 0 the next cycle.
